// File: rtl/pcie_refclk_mon.sv
// -----------------------------------------------------------------------------
// pcie_refclk_mon
//   Multi-channel reference-clock presence/frequency monitor. Each channel's
//   divided refclk toggle is synchronised into the clk domain. Edges in both
//   directions are counted over a fixed window of WIN_CYC clk cycles. The count
//   is checked against [EXP_MIN, EXP_MAX]. A per-channel LOST/ACQ/LOCK state
//   machine with acquire/loss hysteresis qualifies the result.
//
// Ports
//   clk       in   system clock, rising edge
//   rstn      in   synchronous active-low reset
//   en        in   monitor enable; low holds counters and FSMs idle
//   ck_tgl    in   [NUM_CH] asynchronous divided-refclk toggles
//   win_done  out  1-cycle pulse after the last cycle of each window
//   last_cnt  out  [NUM_CH*CNT_W] edge count of the last completed window,
//                  ch0 in the LSBs
//   ch_ok     out  [NUM_CH] channel is in LOCK
//   ch_lost   out  [NUM_CH] 1-cycle pulse on a LOCK->LOST transition
//   all_ok    out  &ch_ok, registered
//   ch_state  out  [2*NUM_CH] per-channel FSM state (debug), ch0 in LSBs
// -----------------------------------------------------------------------------
module pcie_refclk_mon #(
    parameter int NUM_CH   = 2,
    parameter int WIN_CYC  = 4096,
    parameter int CNT_W    = 16,
    parameter int EXP_MIN  = 1000,
    parameter int EXP_MAX  = 1100,
    parameter int GOOD_WIN = 4,
    parameter int BAD_WIN  = 2
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      en,
    input  logic [NUM_CH-1:0]         ck_tgl,
    output logic                      win_done,
    output logic [NUM_CH*CNT_W-1:0]   last_cnt,
    output logic [NUM_CH-1:0]         ch_ok,
    output logic [NUM_CH-1:0]         ch_lost,
    output logic                      all_ok,
    output logic [2*NUM_CH-1:0]       ch_state
);

    localparam int WIN_W    = $clog2(WIN_CYC);
    localparam int STRK_MAX = (GOOD_WIN > BAD_WIN) ? GOOD_WIN : BAD_WIN;
    localparam int STRK_W   = $clog2(STRK_MAX + 1);

    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WIN_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [STRK_W-1:0] GOOD_N   = STRK_W'(GOOD_WIN);
    localparam logic [STRK_W-1:0] BAD_N    = STRK_W'(BAD_WIN);

    typedef enum logic [1:0] {
        ST_LOST = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input path: two synchroniser flops plus one history flop. An edge is
    // any difference between the synchronised value and its history, so
    // rising and falling toggles both count.
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] sync1;
    logic [NUM_CH-1:0] sync2;
    logic [NUM_CH-1:0] hist;
    logic [NUM_CH-1:0] edge_det;

    assign edge_det = sync2 ^ hist;

    // ------------------------------------------------------------------
    // Window and edge counters
    // ------------------------------------------------------------------
    logic [WIN_W-1:0] wcnt;
    logic [CNT_W-1:0] cnt     [NUM_CH];
    logic [CNT_W-1:0] cnt_inc [NUM_CH];

    // Count including the edge seen this cycle, saturating at all-ones.
    // The capture at window end uses this so a final-cycle edge is kept.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_inc[i] = cnt[i];
            if (edge_det[i] && (cnt[i] != CNT_MAX)) begin
                cnt_inc[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1    <= '0;
            sync2    <= '0;
            hist     <= '0;
            wcnt     <= '0;
            win_done <= 1'b0;
            last_cnt <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            // Synchronisers keep running while disabled so re-enable sees
            // no stale difference between sync2 and hist.
            sync1 <= ck_tgl;
            sync2 <= sync1;
            hist  <= sync2;
            if (!en) begin
                wcnt     <= '0;
                win_done <= 1'b0;
                for (int i = 0; i < NUM_CH; i++) begin
                    cnt[i] <= '0;
                end
            end else if (wcnt == WIN_LAST) begin
                wcnt     <= '0;
                win_done <= 1'b1;
                // Counters restart at 0; an edge in the new window's first
                // cycle then lands naturally as count 1.
                for (int i = 0; i < NUM_CH; i++) begin
                    last_cnt[i*CNT_W +: CNT_W] <= cnt_inc[i];
                    cnt[i]                     <= '0;
                end
            end else begin
                wcnt     <= wcnt + WIN_W'(1);
                win_done <= 1'b0;
                for (int i = 0; i < NUM_CH; i++) begin
                    cnt[i] <= cnt_inc[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel lock FSM. Evaluated in the cycle win_done is high, from
    // the registered last_cnt.
    // ------------------------------------------------------------------
    state_t            state     [NUM_CH];
    state_t            state_nx  [NUM_CH];
    logic [STRK_W-1:0] streak    [NUM_CH];
    logic [STRK_W-1:0] streak_nx [NUM_CH];
    logic [NUM_CH-1:0] lost_nx;
    logic [NUM_CH-1:0] good;
    logic [31:0]       cap_w     [NUM_CH];

    always_comb begin
        lost_nx = '0;
        good    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_nx[i]  = state[i];
            streak_nx[i] = streak[i];
            cap_w[i]     = 32'(last_cnt[i*CNT_W +: CNT_W]);
            good[i]      = (cap_w[i] >= 32'(EXP_MIN)) && (cap_w[i] <= 32'(EXP_MAX));

            if (!en) begin
                // Disable is a quiet reset of the qualifier: no ch_lost.
                state_nx[i]  = ST_LOST;
                streak_nx[i] = '0;
            end else if (win_done) begin
                unique case (state[i])
                    ST_LOST: begin
                        if (good[i]) begin
                            if (GOOD_WIN == 1) begin
                                state_nx[i]  = ST_LOCK;
                                streak_nx[i] = '0;
                            end else begin
                                state_nx[i]  = ST_ACQ;
                                streak_nx[i] = STRK_W'(1);
                            end
                        end
                    end
                    ST_ACQ: begin
                        if (good[i]) begin
                            if (streak[i] + STRK_W'(1) == GOOD_N) begin
                                state_nx[i]  = ST_LOCK;
                                streak_nx[i] = '0;
                            end else begin
                                streak_nx[i] = streak[i] + STRK_W'(1);
                            end
                        end else begin
                            state_nx[i]  = ST_LOST;
                            streak_nx[i] = '0;
                        end
                    end
                    ST_LOCK: begin
                        if (good[i]) begin
                            streak_nx[i] = '0;
                        end else if (streak[i] + STRK_W'(1) == BAD_N) begin
                            state_nx[i]  = ST_LOST;
                            streak_nx[i] = '0;
                            lost_nx[i]   = 1'b1;
                        end else begin
                            streak_nx[i] = streak[i] + STRK_W'(1);
                        end
                    end
                    default: begin
                        state_nx[i]  = ST_LOST;
                        streak_nx[i] = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ch_lost <= '0;
            all_ok  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                state[i]  <= ST_LOST;
                streak[i] <= '0;
            end
        end else begin
            ch_lost <= lost_nx;
            all_ok  <= en & (&ch_ok);
            for (int i = 0; i < NUM_CH; i++) begin
                state[i]  <= state_nx[i];
                streak[i] <= streak_nx[i];
            end
        end
    end

    always_comb begin
        ch_ok    = '0;
        ch_state = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_ok[i]          = (state[i] == ST_LOCK);
            ch_state[2*i +: 2] = state[i];
        end
    end

endmodule

// File: tb/tb_pcie_refclk_mon.sv
// -----------------------------------------------------------------------------
// tb_pcie_refclk_mon
//   Bench for pcie_refclk_mon with a short window (64 cycles) and a narrow
//   counter (5 bits) so that lock, loss, boundaries and saturation are all
//   reachable quickly. A window-level reference model runs alongside the DUT
//   and is compared against every output on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_pcie_refclk_mon;

    localparam int NUM_CH   = 2;
    localparam int WIN_CYC  = 64;
    localparam int CNT_W    = 5;
    localparam int EXP_MIN  = 14;
    localparam int EXP_MAX  = 18;
    localparam int GOOD_WIN = 4;
    localparam int BAD_WIN  = 2;
    localparam int SAT_V    = (1 << CNT_W) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rstn   = 1'b0;
    logic                    en     = 1'b0;
    logic [NUM_CH-1:0]       ck_tgl = '0;
    logic                    win_done;
    logic [NUM_CH*CNT_W-1:0] last_cnt;
    logic [NUM_CH-1:0]       ch_ok;
    logic [NUM_CH-1:0]       ch_lost;
    logic                    all_ok;
    logic [2*NUM_CH-1:0]     ch_state;

    pcie_refclk_mon #(
        .NUM_CH  (NUM_CH),
        .WIN_CYC (WIN_CYC),
        .CNT_W   (CNT_W),
        .EXP_MIN (EXP_MIN),
        .EXP_MAX (EXP_MAX),
        .GOOD_WIN(GOOD_WIN),
        .BAD_WIN (BAD_WIN)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .en      (en),
        .ck_tgl  (ck_tgl),
        .win_done(win_done),
        .last_cnt(last_cnt),
        .ch_ok   (ch_ok),
        .ch_lost (ch_lost),
        .all_ok  (all_ok),
        .ch_state(ch_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Works on whole windows: an unbounded integer edge tally per window,
    // clipped to the counter maximum at capture, and a lock flag with
    // good-run / bad-run tallies for hysteresis. The input path is a plain
    // three-sample delay line: the edge counted at clock t is the change
    // between the samples taken at clocks t-3 and t-2.
    int          m_pos;
    int          m_cnt  [NUM_CH];
    int          m_last [NUM_CH];
    bit          m_wd;
    bit          m_lock [NUM_CH];
    int          m_grun [NUM_CH];
    int          m_brun [NUM_CH];
    bit          m_lost [NUM_CH];
    bit          m_all;
    bit [NUM_CH-1:0] smp1, smp2, smp3;
    bit          m_prev_wd;
    bit          m_all_lock;
    bit          m_good;

    initial begin
        m_pos = 0; m_wd = 0; m_all = 0;
        smp1 = '0; smp2 = '0; smp3 = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_cnt[c] = 0; m_last[c] = 0; m_lock[c] = 0;
            m_grun[c] = 0; m_brun[c] = 0; m_lost[c] = 0;
        end
    end

    always @(posedge clk) begin
        if (!rstn) begin
            m_pos = 0; m_wd = 0; m_all = 0;
            smp1 = '0; smp2 = '0; smp3 = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_cnt[c] = 0; m_last[c] = 0; m_lock[c] = 0;
                m_grun[c] = 0; m_brun[c] = 0; m_lost[c] = 0;
            end
        end else begin
            m_prev_wd  = m_wd;
            m_all_lock = 1'b1;
            for (int c = 0; c < NUM_CH; c++) m_all_lock &= m_lock[c];
            m_all = en && m_all_lock;
            for (int c = 0; c < NUM_CH; c++) begin
                m_lost[c] = 0;
                if (!en) begin
                    m_lock[c] = 0; m_grun[c] = 0; m_brun[c] = 0;
                end else if (m_prev_wd) begin
                    m_good = (m_last[c] >= EXP_MIN) && (m_last[c] <= EXP_MAX);
                    if (!m_lock[c]) begin
                        m_grun[c] = m_good ? m_grun[c] + 1 : 0;
                        if (m_grun[c] >= GOOD_WIN) begin
                            m_lock[c] = 1; m_grun[c] = 0; m_brun[c] = 0;
                        end
                    end else begin
                        m_brun[c] = m_good ? 0 : m_brun[c] + 1;
                        if (m_brun[c] >= BAD_WIN) begin
                            m_lock[c] = 0; m_brun[c] = 0; m_lost[c] = 1;
                        end
                    end
                end
                if (en && (smp2[c] != smp3[c])) m_cnt[c]++;
            end
            smp3 = smp2; smp2 = smp1; smp1 = ck_tgl;
            if (en) begin
                if (m_pos == WIN_CYC - 1) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        m_last[c] = (m_cnt[c] > SAT_V) ? SAT_V : m_cnt[c];
                        m_cnt[c]  = 0;
                    end
                    m_wd = 1; m_pos = 0;
                end else begin
                    m_pos++; m_wd = 0;
                end
            end else begin
                m_pos = 0; m_wd = 0;
                for (int c = 0; c < NUM_CH; c++) m_cnt[c] = 0;
            end
        end
    end

    // Continuous comparison of every output against the model.
    logic [NUM_CH-1:0]       e_ok, e_lost;
    logic [NUM_CH*CNT_W-1:0] e_last;
    always @(negedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            e_ok[c]                 = m_lock[c];
            e_lost[c]               = m_lost[c];
            e_last[c*CNT_W +: CNT_W] = m_last[c][CNT_W-1:0];
        end
        chk("model_win_done", 64'(win_done), 64'(m_wd));
        chk("model_last_cnt", 64'(last_cnt), 64'(e_last));
        chk("model_ch_ok",    64'(ch_ok),    64'(e_ok));
        chk("model_ch_lost",  64'(ch_lost),  64'(e_lost));
        chk("model_all_ok",   64'(all_ok),   64'(m_all));
    end

    // ---------------- vector table ----------------
    // Each row drives one 64-cycle frame that starts on the win_done cycle.
    // A toggle driven at frame cycle c is counted at window cycle c+2, so
    // toggles at c<=61 land in the frame's window, c=61 is the window's last
    // cycle and c=62 is the first cycle of the next window.
    typedef struct {
        int   st0;
        int   n0;
        int   n1;
        int   c0;
        int   c1;
        logic ok0;
        logic ok1;
        logic lost0;
        logic lost1;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl [NV];

    function automatic vec_t mk(int st0, int n0, int n1, int c0, int c1,
                                logic ok0, logic ok1, logic lost0, logic lost1);
        vec_t v;
        v.st0 = st0; v.n0 = n0; v.n1 = n1; v.c0 = c0; v.c1 = c1;
        v.ok0 = ok0; v.ok1 = ok1; v.lost0 = lost0; v.lost1 = lost1;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    int k_tick = 0;

    // Both channels toggle every 4 cycles: 16 edges per 64-cycle window.
    task automatic tick4();
        @(negedge clk);
        k_tick++;
        if (k_tick % 4 == 0) ck_tgl = ~ck_tgl;
    endtask

    task automatic wait_wd(input int max_cyc);
        int i;
        i = 0;
        while (!win_done && i < max_cyc) begin
            @(negedge clk);
            i++;
        end
        chk("win_done_seen", 64'(win_done), 64'd1);
    endtask

    // ---------------- main sequence ----------------
    int   nwd;
    bit   pend, done;

    initial begin
        tbl[0]  = mk(61, 1,  0,  1,  0, 0, 0, 0, 0);  // edge in last window cycle
        tbl[1]  = mk(62, 1,  0,  0,  0, 0, 0, 0, 0);  // edge pushed to next window
        tbl[2]  = mk(0,  0,  0,  1,  0, 0, 0, 0, 0);  // ... restarts at 1
        tbl[3]  = mk(0,  14, 0,  14, 0, 0, 0, 0, 0);  // EXP_MIN good
        tbl[4]  = mk(0,  18, 0,  18, 0, 0, 0, 0, 0);  // EXP_MAX good
        tbl[5]  = mk(0,  16, 20, 16, 20, 0, 0, 0, 0);
        tbl[6]  = mk(0,  14, 0,  14, 0, 1, 0, 0, 0);  // 4th good -> lock
        tbl[7]  = mk(0,  13, 18, 13, 18, 1, 0, 0, 0); // EXP_MIN-1 bad
        tbl[8]  = mk(0,  18, 18, 18, 18, 1, 0, 0, 0); // good clears bad run
        tbl[9]  = mk(0,  19, 17, 19, 17, 1, 0, 0, 0); // EXP_MAX+1 bad
        tbl[10] = mk(0,  0,  15, 0,  15, 0, 1, 1, 0); // ch0 lost, ch1 locks
        tbl[11] = mk(0,  14, 64, 14, SAT_V, 0, 1, 0, 0); // ch1 saturates
        tbl[12] = mk(0,  15, 64, 15, SAT_V, 0, 0, 0, 1); // ch1 lost
        tbl[13] = mk(0,  16, 0,  16, 2, 0, 0, 0, 0);  // spill from full toggling
        tbl[14] = mk(0,  17, 0,  17, 0, 1, 0, 0, 0);

        // Reset with toggling inputs.
        rstn = 1'b0; en = 1'b0;
        repeat (4) begin
            @(negedge clk);
            ck_tgl = ~ck_tgl;
        end
        chk("reset_outputs", 64'({win_done, all_ok, ch_ok, ch_lost, last_cnt}), 64'd0);
        ck_tgl = '0;
        rstn   = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_outputs", 64'({win_done, all_ok, ch_ok, ch_lost, last_cnt}), 64'd0);

        // Start monitoring and align to the first window end.
        en = 1'b1;
        @(negedge clk);
        wait_wd(200);

        for (int r = 0; r < NV; r++) begin
            for (int c = 0; c < WIN_CYC; c++) begin
                if (c > 0) @(negedge clk);
                if (c >= tbl[r].st0 && c < tbl[r].st0 + tbl[r].n0) ck_tgl[0] = ~ck_tgl[0];
                if (c < tbl[r].n1) ck_tgl[1] = ~ck_tgl[1];
                if (c == 1 && r > 0) begin
                    chk("row_ch_ok",   64'(ch_ok),   64'({tbl[r-1].ok1, tbl[r-1].ok0}));
                    chk("row_ch_lost", 64'(ch_lost), 64'({tbl[r-1].lost1, tbl[r-1].lost0}));
                end
            end
            @(negedge clk);
            chk("row_win_done", 64'(win_done), 64'd1);
            chk("row_cnt0", 64'(last_cnt[0 +: CNT_W]),     64'(tbl[r].c0));
            chk("row_cnt1", 64'(last_cnt[CNT_W +: CNT_W]), 64'(tbl[r].c1));
        end
        @(negedge clk);
        chk("row_ch_ok",   64'(ch_ok),   64'({tbl[NV-1].ok1, tbl[NV-1].ok0}));
        chk("row_ch_lost", 64'(ch_lost), 64'({tbl[NV-1].lost1, tbl[NV-1].lost0}));

        // Disable while ch0 is locked: no loss pulse, lock cleared.
        en = 1'b0;
        repeat (10) begin
            tick4();
            chk("en_drop_no_lost", 64'(ch_lost), 64'd0);
        end
        chk("en_drop_ch_ok", 64'(ch_ok), 64'd0);
        chk("en_drop_all_ok", 64'(all_ok), 64'd0);
        chk("en_drop_last_held", 64'(last_cnt[0 +: CNT_W]), 64'd17);

        // Re-enable: both channels need GOOD_WIN fresh windows.
        en = 1'b1;
        nwd = 0; pend = 0; done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            tick4();
            if (pend) begin
                pend = 0;
                chk("relock_ch_ok", 64'(ch_ok), (nwd >= GOOD_WIN) ? 64'h3 : 64'h0);
                if (nwd == GOOD_WIN) begin
                    tick4();
                    chk("relock_all_ok", 64'(all_ok), 64'd1);
                    done = 1;
                end
            end
            if (win_done) begin
                nwd++;
                pend = 1;
            end
        end
        chk("relock_done", 64'(done), 64'd1);

        // Randomised traffic with a mid-window reset and random disables.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 3) == 0) ck_tgl[c] = ~ck_tgl[c];
            end
            rstn = !(i >= 700 && i < 703);
            if ($urandom_range(0, 399) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
        end
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
